// File: rtl/comparator_pkg.sv
// Shared types and helpers for the bit-serial magnitude comparator.
// Optional feature macro: COMPARATOR_SIGNED_EN (two's complement operands).
package comparator_pkg;

    typedef enum logic [1:0] {
        CMP_EQ = 2'd0,
        CMP_GT = 2'd1,
        CMP_LT = 2'd2
    } cmp_result_t;

    typedef enum logic [1:0] {
        CMP_IDLE  = 2'd0,
        CMP_SHIFT = 2'd1,
        CMP_DONE  = 2'd2
    } cmp_state_t;

    // One-hot {x, y, z} = {A>B, A==B, A<B}
    function automatic logic [2:0] cmp_onehot(cmp_result_t r);
        logic [2:0] oh;
        oh = 3'b000;
        unique case (r)
            CMP_GT:  oh = 3'b100;
            CMP_EQ:  oh = 3'b010;
            CMP_LT:  oh = 3'b001;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/comparator_bit_update.sv
// Per-bit running-result rule for the LSB-first comparator.
// Optional feature macro: COMPARATOR_SIGNED_EN (inverts the sign-bit rule).
module comparator_bit_update
    import comparator_pkg::*;
(
    input  cmp_result_t cur,
    input  logic        a_bit,
    input  logic        b_bit,
    input  logic        is_sign_bit,
    output cmp_result_t nxt
);

    cmp_result_t on_a_high;
    cmp_result_t on_b_high;

`ifdef COMPARATOR_SIGNED_EN
    // A set sign bit means the operand is negative, so the verdict flips.
    assign on_a_high = is_sign_bit ? CMP_LT : CMP_GT;
    assign on_b_high = is_sign_bit ? CMP_GT : CMP_LT;
`else
    logic unused_sign;
    assign unused_sign = is_sign_bit;
    assign on_a_high   = CMP_GT;
    assign on_b_high   = CMP_LT;
`endif

    // A differing bit overrides the lower-order verdict; equal bits keep it.
    always_comb begin
        nxt = cur;
        unique case (1'b1)
            (a_bit & ~b_bit): nxt = on_a_high;
            (~a_bit & b_bit): nxt = on_b_high;
            default:          nxt = cur;
        endcase
    end

endmodule

// File: rtl/comparator_serial_lsb.sv
// Bit-serial LSB-first magnitude comparator: FSM, bit counter, output registers.
// Optional feature macro: COMPARATOR_SIGNED_EN (two's complement operands).
module comparator_serial_lsb #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic bit_valid,
    input  logic a_bit,
    input  logic b_bit,
    output logic busy,
    output logic done,
    output logic x,
    output logic y,
    output logic z
);
    import comparator_pkg::*;

    localparam int CW = $clog2(WIDTH);

    cmp_state_t      state;
    cmp_state_t      state_nxt;
    cmp_result_t     res;
    cmp_result_t     res_nxt;
    logic [CW-1:0]   cnt;
    logic            last;
    logic            take;

    assign last = (cnt == CW'(WIDTH - 1));
    assign take = (state == CMP_SHIFT) && bit_valid;

    comparator_bit_update u_bit_update (
        .cur         (res),
        .a_bit       (a_bit),
        .b_bit       (b_bit),
        .is_sign_bit (last),
        .nxt         (res_nxt)
    );

    // State register; reset aborts any word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CMP_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: start only counts in IDLE, SHIFT exits on the MSB.
    always_comb begin
        state_nxt = state;
        unique case (state)
            CMP_IDLE: begin
                if (start) begin
                    state_nxt = CMP_SHIFT;
                end
            end
            CMP_SHIFT: begin
                if (bit_valid && last) begin
                    state_nxt = CMP_DONE;
                end
            end
            CMP_DONE: begin
                state_nxt = CMP_IDLE;
            end
            default: begin
                state_nxt = CMP_IDLE;
            end
        endcase
    end

    // Status outputs decode the registered state only.
    always_comb begin
        busy = (state == CMP_SHIFT);
        done = (state == CMP_DONE);
    end

    // Running result and bit counter; bubbles leave both untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res <= CMP_EQ;
            cnt <= '0;
        end else if ((state == CMP_IDLE) && start) begin
            res <= CMP_EQ;
            cnt <= '0;
        end else if (take) begin
            res <= res_nxt;
            if (!last) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Result flags load with the final bit so they are valid with done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {x, y, z} <= 3'b000;
        end else if (take && last) begin
            {x, y, z} <= cmp_onehot(res_nxt);
        end
    end

endmodule

// File: tb/tb_comparator_serial_lsb.sv
// Self-checking bench for comparator_serial_lsb (WIDTH=8).
// Honours COMPARATOR_SIGNED_EN in its reference model.
module tb_comparator_serial_lsb;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic bit_valid = 1'b0;
    logic a_bit = 1'b0;
    logic b_bit = 1'b0;
    logic busy;
    logic done;
    logic x;
    logic y;
    logic z;

    int errors = 0;
    int checks = 0;
    logic [2:0] last_xyz = 3'b000;

    comparator_serial_lsb #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bit_valid (bit_valid),
        .a_bit     (a_bit),
        .b_bit     (b_bit),
        .busy      (busy),
        .done      (done),
        .x         (x),
        .y         (y),
        .z         (z)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word comparison of the operands.
    function automatic logic [2:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b);
`ifdef COMPARATOR_SIGNED_EN
        if ($signed(a) > $signed(b)) return 3'b100;
        if ($signed(a) < $signed(b)) return 3'b001;
        return 3'b010;
`else
        if (a > b) return 3'b100;
        if (a < b) return 3'b001;
        return 3'b010;
`endif
    endfunction

    // mode: 0 no bubbles, 1 bubble before every bit after the first,
    // 2 random bubbles. noise: IDLE bit pulses and start held in SHIFT.
    task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int mode, input bit noise);
        logic [2:0] exp;
        bit bub;
        exp = model(a, b);
        if (noise) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                bit_valid = 1'b1;
                a_bit = 1'b1;
                b_bit = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check("idle_ignore_busy", busy, 1'b0);
                check("idle_ignore_done", done, 1'b0);
            end
        end
        @(negedge clk);
        start = 1'b1;
        bit_valid = noise;
        a_bit = 1'b1;
        b_bit = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("busy_after_start", busy, 1'b1);
        check("no_done_at_start", done, 1'b0);
        start = noise;
        for (int i = 0; i < W; i++) begin
            bub = (mode == 1 && i > 0) ||
                  (mode == 2 && $urandom_range(0, 1) == 1);
            if (bub) begin
                bit_valid = 1'b0;
                a_bit = ~a[i];
                b_bit = ~b[i];
                @(posedge clk);
                @(negedge clk);
                check("busy_in_bubble", busy, 1'b1);
                check("no_done_in_bubble", done, 1'b0);
            end
            bit_valid = 1'b1;
            a_bit = a[i];
            b_bit = b[i];
            if (i == W - 1) start = 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (i < W - 1) begin
                check("busy_mid_word", busy, 1'b1);
                check("no_early_done", done, 1'b0);
                check("xyz_hold_mid", {x, y, z}, last_xyz);
            end
        end
        bit_valid = 1'b0;
        check("done_after_last", done, 1'b1);
        check("busy_clear_done", busy, 1'b0);
        check("xyz_result", {x, y, z}, exp);
        last_xyz = exp;
        @(posedge clk);
        @(negedge clk);
        check("single_done", done, 1'b0);
        check("idle_after_done", busy, 1'b0);
        check("xyz_hold_post", {x, y, z}, exp);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] ff;
        logic [W-1:0] zz;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_xyz", {x, y, z}, 3'b000);
        rst_n = 1'b1;

        run_cmp(8'hA5, 8'h5A, 0, 1'b0);
        run_cmp(8'h3C, 8'h3C, 0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("xyz_stable_idle", {x, y, z}, 3'b010);
            check("done_quiet_idle", done, 1'b0);
        end
        run_cmp(8'h01, 8'h80, 1, 1'b0);
        run_cmp(8'h12, 8'h34, 0, 1'b1);

        // Abort after four bits of A=FF, B=00.
        ff = 8'hFF;
        zz = 8'h00;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1;
            a_bit = ff[i];
            b_bit = zz[i];
            @(posedge clk);
            @(negedge clk);
        end
        bit_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_xyz", {x, y, z}, 3'b000);
        last_xyz = 3'b000;
        @(negedge clk);
        check("abort_no_done", done, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_stays_idle", busy, 1'b0);
        run_cmp(ff, zz, 0, 1'b0);

        run_cmp(8'h80, 8'h01, 0, 1'b0);
        run_cmp(8'h7F, 8'h80, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 4) == 0) ? ra : W'($urandom);
            run_cmp(ra, rb, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
